dvp_raw_crop: RTL and testbench
===============================

// Module: dvp_raw_crop
// PURPOSE
//  Crops a rectangular window out of the registered DVP raw stream (out_href/out_vsync/out_raw) produced by the video-input stage.
//  Sits directly downstream of the DVP input block on its pixel clock.
//  Forwards only pixels inside the window, keeping DVP framing (href per line, active-high vsync pulse between frames).
//  Window geometry is latched once per frame, so software can update it at any time without tearing.
// PARAMETERS
//  BITS   8   raw pixel width
//  CW     16  coordinate/counter width (max 65535 pixels per line or lines per frame)
// PORTS
//  clk          in   1     pixel clock (fed from out_pclk of the DVP input stage)
//  reset        in   1     synchronous, active-high
//  crop_en      in   1     1: crop; 0: bypass (stream forwarded unchanged); latched per frame
//  crop_x       in   CW    first column of window (0-based)
//  crop_y       in   CW    first line of window (0-based)
//  crop_w       in   CW    window width in pixels
//  crop_h       in   CW    window height in lines
//  in_href      in   1     line valid, active-high
//  in_vsync     in   1     frame sync, active-high pulse before each frame
//  in_raw       in   BITS  raw bayer pixel
//  out_href     out  1     cropped line valid
//  out_vsync    out  1     in_vsync delayed 1 cycle
//  out_raw      out  BITS  cropped pixel; 0 when out_href=0
//  cfg_err      out  1     sticky per frame: latched crop_w==0 or crop_h==0
// BEHAVIOUR
//  Interface: one clock clk; reset synchronous, active-high.
//  Reset values: out_href=0, out_vsync=0, out_raw=0, cfg_err=0, counters=0, latched config=0 (bypass), state=WAIT_SYNC.
//  FSM:
//   WAIT_SYNC: out_href forced 0; out_vsync forwarded. On vsync rise (in_vsync & ~prev_vsync) -> ACTIVE.
//   ACTIVE: normal operation. Reset returns to WAIT_SYNC, so a reset mid-frame never emits a partial frame.
//  Config latch: on vsync rise, crop_en/x/y/w/h are captured into shadow registers; cfg_err <= (w==0)|(h==0).
//   Values changed mid-frame take effect only on the next frame.
//  Counters:
//   col: 0 on the first href-high cycle of a line, +1 each further href-high cycle.
//   row: 0 at vsync rise; +1 on each href falling edge.
//  Window test uses CW+1-bit sums, no wrap: col>=x & col<x+w & row>=y & row<y+h.
//  Output, registered, latency exactly 1 cycle for all outputs:
//   out_vsync <= in_vsync.
//   Bypass: out_href <= in_href, out_raw <= in_raw.
//   Crop: out_href <= in_href & inwin; out_raw <= inwin ? in_raw : 0.
//  Boundaries:
//   Window past line end or frame end: only the existing pixels/lines are output; no padding.
//   cfg_err=1: no href for the whole frame; vsync still forwarded.
//   x=0,w=full width: output line identical to input line.
//   Line of unexpected length: the counter simply restarts at the next href rise.
//   vsync rise while in_href=1: row cleared; the current line continues as row 0.
// STRUCTURE
//  Shared include dvp_defs.vh: CW default, vsync/href polarity constants shared with the DVP input and colorbar blocks.
//  Sub-module dvp_pos_counter (href/vsync edge detect + col/row counters, outputs vs_rise, col, row).
//   Reused by later ISP stages.
//  Top: config shadow regs, FSM, window compare, output regs.
// TESTING
//  Stimulus is a 16x8 frame, vsync pulse 4 cycles, 4-cycle hblank, pixel value = row*16+col.
//  1) Bypass (en=0): output equals input delayed exactly 1 cycle, bit-exact, for 3 frames.
//  2) Crop x=2,y=1,w=4,h=3: 3 lines of 4 pixels each; first line = 18,19,20,21; last line = 50..53.
//  3) Change crop_x 2->5 mid-frame: the current frame still uses 2; next frame's first pixel = 21.
//  4) x=14,w=8 (window past line end): lines of 2 pixels (14,15); y=6,h=5 gives 2 lines only.
//  5) w=0: cfg_err=1 after vsync rise, no out_href for that frame; w=4 on the next frame -> cfg_err=0.
//  6) Reset asserted mid-frame: no out_href until the next vsync rise; first frame afterwards matches expected.

Source files
------------

// File: rtl/dvp_raw_crop_pkg.sv
// Shared DVP definitions: default widths, sync polarities and the crop FSM encoding.
package dvp_raw_crop_pkg;

  // Default raw pixel width and coordinate/counter width.
  localparam int DVP_BITS = 8;
  localparam int DVP_CW   = 16;

  // Active levels of the DVP framing signals, shared with the input and colorbar blocks.
  localparam logic VSYNC_ACTIVE = 1'b1;
  localparam logic HREF_ACTIVE  = 1'b1;

  // Crop FSM states: wait for a frame start, then crop normally.
  localparam logic [0:0] ST_WAIT_SYNC = 1'b0;
  localparam logic [0:0] ST_ACTIVE    = 1'b1;

endpackage

// File: rtl/dvp_pos_counter.sv
// Pixel position tracker for a DVP stream: detects vsync/href edges and
// produces the column and row of the pixel currently on the input.
// col and row are valid in the same cycle as the pixel they describe.
module dvp_pos_counter
  import dvp_raw_crop_pkg::*;
#(
  parameter int CW = DVP_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_href,
  input  logic          i_vsync,
  output logic          o_vs_rise,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row
);

  logic          w_href;
  logic          w_vsync;
  logic          w_href_fall;
  logic          r_href_d;
  logic          r_vsync_d;
  logic [CW-1:0] r_col_nxt;
  logic [CW-1:0] r_row;

  assign w_href      = (i_href  == HREF_ACTIVE);
  assign w_vsync     = (i_vsync == VSYNC_ACTIVE);
  assign o_vs_rise   = w_vsync & ~r_vsync_d;
  assign w_href_fall = ~w_href & r_href_d;

  // The first href-high cycle of a line (previous cycle low) is always column 0,
  // so a line of unexpected length simply restarts at the next href rise.
  assign o_col = r_href_d ? r_col_nxt : '0;

  // A vsync rise clears the row immediately, so a line in flight continues as row 0.
  assign o_row = o_vs_rise ? '0 : r_row;

  // Edge-detect history and position counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
      r_col_nxt <= '0;
      r_row     <= '0;
    end else begin
      r_href_d  <= w_href;
      r_vsync_d <= w_vsync;
      if (w_href) begin
        r_col_nxt <= o_col + CW'(1);
      end
      if (o_vs_rise) begin
        r_row <= '0;
      end else if (w_href_fall) begin
        r_row <= r_row + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dvp_raw_crop.sv
// Crops a rectangular window out of a registered DVP raw stream while keeping
// DVP framing. Window geometry is shadowed at each vsync rise so it can be
// rewritten at any time without tearing. All outputs have one cycle of latency.
module dvp_raw_crop
  import dvp_raw_crop_pkg::*;
#(
  parameter int BITS = DVP_BITS,
  parameter int CW   = DVP_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            crop_en,
  input  logic [CW-1:0]   crop_x,
  input  logic [CW-1:0]   crop_y,
  input  logic [CW-1:0]   crop_w,
  input  logic [CW-1:0]   crop_h,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_raw,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            cfg_err
);

  // Position tracking.
  logic          w_vs_rise;
  logic [CW-1:0] w_col;
  logic [CW-1:0] w_row;

  // Normalised framing inputs.
  logic w_href;
  logic w_vsync;

  // Shadow configuration, latched once per frame.
  logic          r_en;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [CW-1:0] r_w;
  logic [CW-1:0] r_h;
  logic          r_cfg_err;

  // FSM.
  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  // Window compare.
  logic [CW:0] w_x_end;
  logic [CW:0] w_y_end;
  logic        w_in_win;
  logic        w_pass;
  logic        w_href_out;

  // Output registers.
  logic            r_out_href;
  logic            r_out_vsync;
  logic [BITS-1:0] r_out_raw;

  assign w_href  = (in_href  == HREF_ACTIVE);
  assign w_vsync = (in_vsync == VSYNC_ACTIVE);

  dvp_pos_counter #(
    .CW (CW)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .i_href    (in_href),
    .i_vsync   (in_vsync),
    .o_vs_rise (w_vs_rise),
    .o_col     (w_col),
    .o_row     (w_row)
  );

  // Capture the window geometry and its validity at the start of each frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_cfg_err <= 1'b0;
    end else if (w_vs_rise) begin
      r_en      <= crop_en;
      r_x       <= crop_x;
      r_y       <= crop_y;
      r_w       <= crop_w;
      r_h       <= crop_h;
      r_cfg_err <= (crop_w == '0) | (crop_h == '0);
    end
  end

  // Next-state logic: stay silent until a frame boundary has been seen.
  always_comb begin
    // NOTE: a default assignment on entry keeps every path assigned, so no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_SYNC: if (w_vs_rise) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE:    w_state_nxt = ST_ACTIVE;
      default:      w_state_nxt = ST_WAIT_SYNC;
    endcase
  end

  // State register; reset always drops back to waiting for a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window ends are computed one bit wider so x+w and y+h never wrap.
  assign w_x_end  = {1'b0, r_x} + {1'b0, r_w};
  assign w_y_end  = {1'b0, r_y} + {1'b0, r_h};
  assign w_in_win = (w_col >= r_x) && ({1'b0, w_col} < w_x_end) &&
                    (w_row >= r_y) && ({1'b0, w_row} < w_y_end);

  // In crop mode an invalid (zero-sized) window suppresses the whole frame;
  // bypass forwards the stream unchanged regardless of the window settings.
  assign w_pass     = r_en ? (w_in_win & ~r_cfg_err) : 1'b1;
  assign w_href_out = (r_state == ST_ACTIVE) & w_href & w_pass;

  // Registered outputs; pixel data is forced to zero whenever href is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_href  <= 1'b0;
      r_out_vsync <= 1'b0;
      r_out_raw   <= '0;
    end else begin
      r_out_vsync <= w_vsync;
      r_out_href  <= w_href_out;
      r_out_raw   <= w_href_out ? in_raw : '0;
    end
  end

  assign out_href  = r_out_href  ? HREF_ACTIVE  : ~HREF_ACTIVE;
  assign out_vsync = r_out_vsync ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
  assign out_raw   = r_out_raw;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_dvp_raw_crop.sv
// Directed bench for dvp_raw_crop: 16x8 frames, 4-cycle vsync, 4-cycle hblank,
// pixel value = row*16+col. A per-cycle scoreboard holds the expected outputs
// and a capture queue collects emitted pixels for line/count checks.
module tb_dvp_raw_crop;

  logic        clk;
  logic        reset;
  logic        crop_en;
  logic [15:0] crop_x;
  logic [15:0] crop_y;
  logic [15:0] crop_w;
  logic [15:0] crop_h;
  logic        in_href;
  logic        in_vsync;
  logic [7:0]  in_raw;
  logic        out_href;
  logic        out_vsync;
  logic [7:0]  out_raw;
  logic        cfg_err;

  typedef struct packed {
    logic       v;
    logic       h;
    logic [7:0] p;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cap[$];
  logic       model_active;
  int         n_cmp;
  int         n_fail;

  dvp_raw_crop #(
    .BITS (8),
    .CW   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .crop_en   (crop_en),
    .crop_x    (crop_x),
    .crop_y    (crop_y),
    .crop_w    (crop_w),
    .crop_h    (crop_h),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_raw    (in_raw),
    .out_href  (out_href),
    .out_vsync (out_vsync),
    .out_raw   (out_raw),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap.size()) return {24'd0, cap[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Drive one cycle of input, push its expected output, then compare after the edge.
  task automatic drive(input logic v, input logic h, input logic [7:0] p,
                       input logic r, input logic eh);
    exp_t e;
    in_vsync = v;
    in_href  = h;
    in_raw   = p;
    reset    = r;
    sb.push_back('{v: (r ? 1'b0 : v), h: eh, p: (eh ? p : 8'd0)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("out_vsync", {31'd0, out_vsync}, {31'd0, e.v});
    check("out_href",  {31'd0, out_href},  {31'd0, e.h});
    check("out_raw",   {24'd0, out_raw},   {24'd0, e.p});
    if (out_href === 1'b1) cap.push_back(out_raw);
  endtask

  // One frame; e/x/y/w/h are the settings the DUT is expected to have latched.
  // chg_line: line at which crop_x is rewritten to chg_x; rst_line: line at which reset pulses.
  task automatic send_frame(input logic e, input int x, input int y, input int w, input int h,
                            input int chg_line, input int chg_x, input int rst_line);
    logic err;
    logic inwin;
    logic eh;
    err = (w == 0) || (h == 0);
    cap.delete();
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    model_active = 1'b1;
    check("cfg_err_at_vsync", {31'd0, cfg_err}, {31'd0, err});
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      if (r == chg_line) crop_x = 16'(chg_x);
      if (r == rst_line) begin
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        model_active = 1'b0;
        cap.delete();
        check("cfg_err_after_reset", {31'd0, cfg_err}, 32'd0);
      end
      for (int c = 0; c < 16; c++) begin
        inwin = (c >= x) && (c < x + w) && (r >= y) && (r < y + h);
        eh    = model_active && (!e || (!err && inwin));
        drive(1'b0, 1'b1, 8'(r * 16 + c), 1'b0, eh);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic set_cfg(input logic e, input int x, input int y, input int w, input int h);
    crop_en = e;
    crop_x  = 16'(x);
    crop_y  = 16'(y);
    crop_w  = 16'(w);
    crop_h  = 16'(h);
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    model_active = 1'b0;
    set_cfg(1'b0, 0, 0, 16, 8);

    // Reset state.
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    // Stream before any vsync must stay silent.
    drive(1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Bypass for three frames: bit-exact copy delayed by one cycle.
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, 0, 0, 16, 8, -1, 0, -1);
      check("bypass_count", cap.size(), 32'd128);
    end

    // Basic crop window.
    set_cfg(1'b1, 2, 1, 4, 3);
    send_frame(1'b1, 2, 1, 4, 3, -1, 0, -1);
    check("crop_count", cap.size(), 32'd12);
    check("crop_first", cap_at(0), 32'd18);
    check("crop_line0_end", cap_at(3), 32'd21);
    check("crop_last_line_start", cap_at(8), 32'd50);
    check("crop_last", cap_at(11), 32'd53);

    // crop_x rewritten mid-frame: applies only from the next frame.
    send_frame(1'b1, 2, 1, 4, 3, 4, 5, -1);
    check("midchg_first", cap_at(0), 32'd18);
    check("midchg_count", cap.size(), 32'd12);
    send_frame(1'b1, 5, 1, 4, 3, -1, 0, -1);
    check("nextframe_first", cap_at(0), 32'd21);
    check("nextframe_count", cap.size(), 32'd12);

    // Window running past line end and frame end.
    set_cfg(1'b1, 14, 6, 8, 5);
    send_frame(1'b1, 14, 6, 8, 5, -1, 0, -1);
    check("edge_count", cap.size(), 32'd4);
    check("edge_p0", cap_at(0), 32'd110);
    check("edge_p1", cap_at(1), 32'd111);
    check("edge_p2", cap_at(2), 32'd126);
    check("edge_p3", cap_at(3), 32'd127);

    // Full-width window equals the input.
    set_cfg(1'b1, 0, 0, 16, 8);
    send_frame(1'b1, 0, 0, 16, 8, -1, 0, -1);
    check("full_count", cap.size(), 32'd128);

    // Zero width: error flag, no output; then recovery.
    set_cfg(1'b1, 2, 1, 0, 3);
    send_frame(1'b1, 2, 1, 0, 3, -1, 0, -1);
    check("zero_w_count", cap.size(), 32'd0);
    check("zero_w_err_end", {31'd0, cfg_err}, 32'd1);
    set_cfg(1'b1, 2, 1, 4, 3);
    send_frame(1'b1, 2, 1, 4, 3, -1, 0, -1);
    check("recover_err", {31'd0, cfg_err}, 32'd0);
    check("recover_count", cap.size(), 32'd12);

    // Reset in mid-frame: silence until the next vsync, then a normal frame.
    send_frame(1'b1, 2, 1, 4, 3, -1, 0, 3);
    check("post_reset_silent", cap.size(), 32'd0);
    send_frame(1'b1, 2, 1, 4, 3, -1, 0, -1);
    check("post_reset_count", cap.size(), 32'd12);
    check("post_reset_first", cap_at(0), 32'd18);
    check("post_reset_last", cap_at(11), 32'd53);

    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
